// File: rtl/dallanma_paket.sv
// Shared types and constants for the branch-resolution block.
// The FIFO entry keeps just enough to check a prediction and rebuild the fall-through PC.
package dallanma_paket;

  localparam int unsigned PC_BIT = 32;
  localparam logic [PC_BIT-1:0] PC_ADIM = 32'd4;

  typedef enum logic [0:0] {
    NORMAL,
    TEMIZLE
  } durum_t;

  typedef struct packed {
    logic [PC_BIT-1:0] ps;
    logic              ongoru;
  } kayit_t;

  // Correct next PC once the real direction is known.
  function automatic logic [PC_BIT-1:0] dogru_adres(input logic              atladi,
                                                    input logic [PC_BIT-1:0] hedef,
                                                    input logic [PC_BIT-1:0] ps);
    return atladi ? hedef : ps + PC_ADIM;
  endfunction

endpackage

// File: rtl/ongoru_kuyrugu.sv
// Circular FIFO of in-flight predictions; pointers carry one extra wrap bit so
// full and empty fall out of a pointer compare. The caller must not push while full.
module ongoru_kuyrugu
  import dallanma_paket::*;
#(
  parameter int unsigned DERINLIK = 4,
  localparam int unsigned AW = $clog2(DERINLIK)
) (
  input  logic          saat,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          push,
  input  kayit_t        push_data,
  input  logic          pop,
  output kayit_t        head,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  kayit_t      mem [DERINLIK];
  logic [AW:0] wptr_q;
  logic [AW:0] rptr_q;

  always_ff @(posedge saat or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (clear) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge saat) begin
    if (push && !clear) mem[wptr_q[AW-1:0]] <= push_data;
  end

  always_comb begin
    head  = mem[rptr_q[AW-1:0]];
    count = wptr_q - rptr_q;
    empty = (wptr_q == rptr_q);
    full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  end

endmodule

// File: rtl/dallanma_cozucu.sv
// Branch resolution: checks queued predictions against execute outcomes in order,
// reports the result, redirects fetch on a mispredict and runs a fixed-length flush.
module dallanma_cozucu
  import dallanma_paket::*;
#(
  parameter int unsigned KUYRUK_DERINLIK = 4,
  parameter int unsigned TEMIZLE_CEVRIM  = 2,
  parameter int unsigned SAYAC_BIT       = 16
) (
  input  logic                 i_saat,
  input  logic                 i_reset_n,
  input  logic                 i_ongoru_gecerli,
  input  logic                 i_ongoru,
  input  logic [PC_BIT-1:0]    i_ongoru_ps,
  output logic                 o_kuyruk_dolu,
  input  logic                 i_sonuc_gecerli,
  input  logic                 i_sonuc_atladi,
  input  logic [PC_BIT-1:0]    i_sonuc_hedef,
  output logic                 o_buyruk_atladi,
  output logic                 o_guncelle_gecerli,
  output logic                 o_ongoru_yanlis,
  output logic                 o_yonlendir_gecerli,
  output logic [PC_BIT-1:0]    o_yonlendir_adres,
  output logic                 o_temizle,
  output logic                 o_hata,
  output logic [SAYAC_BIT-1:0] o_dogru_sayac,
  output logic [SAYAC_BIT-1:0] o_yanlis_sayac
);

  localparam int unsigned AW = $clog2(KUYRUK_DERINLIK);
  localparam int unsigned SW = (TEMIZLE_CEVRIM > 1) ? $clog2(TEMIZLE_CEVRIM) : 1;
  localparam logic [AW:0]          DOLU_SAYI     = (AW + 1)'(KUYRUK_DERINLIK);
  localparam logic [SW-1:0]        TEMIZLE_YUKLE = SW'(TEMIZLE_CEVRIM - 1);
  localparam logic [SAYAC_BIT-1:0] SAYAC_MAX     = '1;

  durum_t              durum_q;
  logic [SW-1:0]       temizle_sayac_q;
  logic                temizle_q;
  logic                guncelle_q;
  logic                atladi_q;
  logic                yanlis_q;
  logic                yonlendir_q;
  logic [PC_BIT-1:0]   adres_q;
  logic                hata_q;
  logic [SAYAC_BIT-1:0] dogru_q;
  logic [SAYAC_BIT-1:0] yanlis_sayac_q;

  kayit_t      kuyruk_bas;
  kayit_t      yeni_kayit;
  logic        kuyruk_full;
  logic        kuyruk_empty;
  logic [AW:0] kuyruk_count;

  logic normal;
  logic pop;
  logic push;
  logic yanlis;
  logic hata_olay;

  always_comb begin
    normal     = (durum_q == NORMAL);
    pop        = normal && i_sonuc_gecerli && !kuyruk_empty;
    yanlis     = pop && (kuyruk_bas.ongoru != i_sonuc_atladi);
    // A mispredict wipes the queue on this edge, so a same-cycle push is dropped.
    push       = normal && !yanlis && i_ongoru_gecerli && (!kuyruk_full || pop);
    hata_olay  = normal && ((i_ongoru_gecerli && kuyruk_full && !pop) ||
                            (i_sonuc_gecerli && kuyruk_empty));
    yeni_kayit = '{ps: i_ongoru_ps, ongoru: i_ongoru};
  end

  ongoru_kuyrugu #(
    .DERINLIK (KUYRUK_DERINLIK)
  ) u_kuyruk (
    .saat      (i_saat),
    .reset_n   (i_reset_n),
    .clear     (yanlis),
    .push      (push),
    .push_data (yeni_kayit),
    .pop       (pop),
    .head      (kuyruk_bas),
    .full      (kuyruk_full),
    .empty     (kuyruk_empty),
    .count     (kuyruk_count)
  );

  // o_temizle rises on the same edge that raises o_ongoru_yanlis.
  always_ff @(posedge i_saat or negedge i_reset_n) begin
    if (!i_reset_n) begin
      durum_q         <= NORMAL;
      temizle_sayac_q <= '0;
      temizle_q       <= 1'b0;
    end else begin
      case (durum_q)
        NORMAL: begin
          if (yanlis) begin
            durum_q         <= TEMIZLE;
            temizle_sayac_q <= TEMIZLE_YUKLE;
            temizle_q       <= 1'b1;
          end
        end
        TEMIZLE: begin
          if (temizle_sayac_q == '0) begin
            durum_q   <= NORMAL;
            temizle_q <= 1'b0;
          end else begin
            temizle_sayac_q <= temizle_sayac_q - 1'b1;
          end
        end
        default: begin
          durum_q   <= NORMAL;
          temizle_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_saat or negedge i_reset_n) begin
    if (!i_reset_n) begin
      guncelle_q     <= 1'b0;
      atladi_q       <= 1'b0;
      yanlis_q       <= 1'b0;
      yonlendir_q    <= 1'b0;
      adres_q        <= '0;
      hata_q         <= 1'b0;
      dogru_q        <= '0;
      yanlis_sayac_q <= '0;
    end else begin
      guncelle_q  <= pop;
      yanlis_q    <= yanlis;
      yonlendir_q <= yanlis;
      hata_q      <= hata_q | hata_olay;
      if (pop) atladi_q <= i_sonuc_atladi;
      if (yanlis) adres_q <= dogru_adres(i_sonuc_atladi, i_sonuc_hedef, kuyruk_bas.ps);
      if (pop && !yanlis && (dogru_q != SAYAC_MAX)) dogru_q <= dogru_q + 1'b1;
      if (yanlis && (yanlis_sayac_q != SAYAC_MAX)) yanlis_sayac_q <= yanlis_sayac_q + 1'b1;
    end
  end

  always_comb begin
    o_kuyruk_dolu       = (kuyruk_count == DOLU_SAYI);
    o_buyruk_atladi     = atladi_q;
    o_guncelle_gecerli  = guncelle_q;
    o_ongoru_yanlis     = yanlis_q;
    o_yonlendir_gecerli = yonlendir_q;
    o_yonlendir_adres   = adres_q;
    o_temizle           = temizle_q;
    o_hata              = hata_q;
    o_dogru_sayac       = dogru_q;
    o_yanlis_sayac      = yanlis_sayac_q;
  end

endmodule

// File: tb/tb_dallanma_cozucu.sv
// Directed bench for dallanma_cozucu: hand-computed expectations checked with immediate assertions.
module tb_dallanma_cozucu;

  logic        saat = 1'b0;
  logic        reset_n;
  logic        ongoru_gecerli;
  logic        ongoru;
  logic [31:0] ongoru_ps;
  logic        kuyruk_dolu;
  logic        sonuc_gecerli;
  logic        sonuc_atladi;
  logic [31:0] sonuc_hedef;
  logic        buyruk_atladi;
  logic        guncelle_gecerli;
  logic        ongoru_yanlis;
  logic        yonlendir_gecerli;
  logic [31:0] yonlendir_adres;
  logic        temizle;
  logic        hata;
  logic [15:0] dogru_sayac;
  logic [15:0] yanlis_sayac;

  int checks = 0;
  int errors = 0;

  always #5 saat = ~saat;

  dallanma_cozucu #(
    .KUYRUK_DERINLIK (4),
    .TEMIZLE_CEVRIM  (2),
    .SAYAC_BIT       (16)
  ) dut (
    .i_saat              (saat),
    .i_reset_n           (reset_n),
    .i_ongoru_gecerli    (ongoru_gecerli),
    .i_ongoru            (ongoru),
    .i_ongoru_ps         (ongoru_ps),
    .o_kuyruk_dolu       (kuyruk_dolu),
    .i_sonuc_gecerli     (sonuc_gecerli),
    .i_sonuc_atladi      (sonuc_atladi),
    .i_sonuc_hedef       (sonuc_hedef),
    .o_buyruk_atladi     (buyruk_atladi),
    .o_guncelle_gecerli  (guncelle_gecerli),
    .o_ongoru_yanlis     (ongoru_yanlis),
    .o_yonlendir_gecerli (yonlendir_gecerli),
    .o_yonlendir_adres   (yonlendir_adres),
    .o_temizle           (temizle),
    .o_hata              (hata),
    .o_dogru_sayac       (dogru_sayac),
    .o_yanlis_sayac      (yanlis_sayac)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge saat);
    #1;
  endtask

  task automatic idle_inputs();
    ongoru_gecerli = 1'b0;
    ongoru         = 1'b0;
    ongoru_ps      = 32'h0;
    sonuc_gecerli  = 1'b0;
    sonuc_atladi   = 1'b0;
    sonuc_hedef    = 32'h0;
  endtask

  task automatic push(input logic [31:0] ps, input logic o);
    ongoru_gecerli = 1'b1;
    ongoru_ps      = ps;
    ongoru         = o;
  endtask

  task automatic resolve(input logic a, input logic [31:0] h);
    sonuc_gecerli = 1'b1;
    sonuc_atladi  = a;
    sonuc_hedef   = h;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge saat);
    @(negedge saat);
    reset_n = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_dolu"}, {31'b0, kuyruk_dolu}, 32'h0);
    chk({tag, "_guncelle"}, {31'b0, guncelle_gecerli}, 32'h0);
    chk({tag, "_atladi"}, {31'b0, buyruk_atladi}, 32'h0);
    chk({tag, "_yanlis"}, {31'b0, ongoru_yanlis}, 32'h0);
    chk({tag, "_yonlendir"}, {31'b0, yonlendir_gecerli}, 32'h0);
    chk({tag, "_adres"}, yonlendir_adres, 32'h0);
    chk({tag, "_temizle"}, {31'b0, temizle}, 32'h0);
    chk({tag, "_hata"}, {31'b0, hata}, 32'h0);
    chk({tag, "_dogru"}, {16'b0, dogru_sayac}, 32'h0);
    chk({tag, "_yanlis_sayac"}, {16'b0, yanlis_sayac}, 32'h0);
  endtask

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    #2;
    check_all_zero("reset");
    do_reset();
    #1;
    check_all_zero("release");

    // 1: fill, overflow push, then drain to prove the dropped entry never landed
    push(32'h10, 1'b0); tick();
    push(32'h14, 1'b0); tick();
    push(32'h18, 1'b0); tick();
    chk("t1_dolu_3", {31'b0, kuyruk_dolu}, 32'h0);
    push(32'h1C, 1'b0); tick();
    chk("t1_dolu_4", {31'b0, kuyruk_dolu}, 32'h1);
    chk("t1_hata_4", {31'b0, hata}, 32'h0);
    push(32'h50, 1'b1); tick();
    chk("t1_hata_5", {31'b0, hata}, 32'h1);
    chk("t1_dolu_5", {31'b0, kuyruk_dolu}, 32'h1);
    idle_inputs();
    resolve(1'b0, 32'h0); tick();
    chk("t1_pop1_dolu", {31'b0, kuyruk_dolu}, 32'h0);
    chk("t1_pop1_guncelle", {31'b0, guncelle_gecerli}, 32'h1);
    tick(); tick(); tick();
    chk("t1_pop4_dogru", {16'b0, dogru_sayac}, 32'd4);
    chk("t1_pop4_yanlis", {31'b0, ongoru_yanlis}, 32'h0);
    tick();
    chk("t1_pop5_guncelle", {31'b0, guncelle_gecerli}, 32'h0);
    chk("t1_pop5_dogru", {16'b0, dogru_sayac}, 32'd4);

    do_reset();

    // 2: correct taken prediction
    push(32'h100, 1'b1); tick();
    idle_inputs(); tick();
    resolve(1'b1, 32'h0); tick();
    chk("t2_guncelle", {31'b0, guncelle_gecerli}, 32'h1);
    chk("t2_atladi", {31'b0, buyruk_atladi}, 32'h1);
    chk("t2_yanlis", {31'b0, ongoru_yanlis}, 32'h0);
    chk("t2_dogru", {16'b0, dogru_sayac}, 32'd1);
    idle_inputs(); tick();
    chk("t2_guncelle_end", {31'b0, guncelle_gecerli}, 32'h0);

    // 3: predicted taken, actually not taken; same-cycle push must be dropped
    push(32'h200, 1'b1); tick();
    push(32'h204, 1'b0); tick();
    push(32'h600, 1'b1);
    resolve(1'b0, 32'h0); tick();
    chk("t3_yanlis", {31'b0, ongoru_yanlis}, 32'h1);
    chk("t3_yonlendir", {31'b0, yonlendir_gecerli}, 32'h1);
    chk("t3_adres", yonlendir_adres, 32'h204);
    chk("t3_temizle1", {31'b0, temizle}, 32'h1);
    chk("t3_yanlis_sayac", {16'b0, yanlis_sayac}, 32'd1);
    chk("t3_atladi", {31'b0, buyruk_atladi}, 32'h0);
    chk("t3_dogru", {16'b0, dogru_sayac}, 32'd1);
    push(32'h999, 1'b0);
    resolve(1'b0, 32'h0); tick();
    chk("t3_temizle2", {31'b0, temizle}, 32'h1);
    chk("t3_flush_guncelle", {31'b0, guncelle_gecerli}, 32'h0);
    chk("t3_flush_yanlis", {31'b0, ongoru_yanlis}, 32'h0);
    chk("t3_flush_hata", {31'b0, hata}, 32'h0);
    idle_inputs(); tick();
    chk("t3_temizle3", {31'b0, temizle}, 32'h0);

    // 5: queue must be empty after the flush; then push+pop while full
    push(32'h500, 1'b1); tick();
    push(32'h504, 1'b1); tick();
    push(32'h508, 1'b1); tick();
    chk("t5_dolu_3", {31'b0, kuyruk_dolu}, 32'h0);
    push(32'h50C, 1'b1); tick();
    chk("t5_dolu_4", {31'b0, kuyruk_dolu}, 32'h1);
    push(32'h510, 1'b0);
    resolve(1'b1, 32'h0); tick();
    chk("t5_both_dolu", {31'b0, kuyruk_dolu}, 32'h1);
    chk("t5_both_hata", {31'b0, hata}, 32'h0);
    chk("t5_both_guncelle", {31'b0, guncelle_gecerli}, 32'h1);
    chk("t5_both_dogru", {16'b0, dogru_sayac}, 32'd2);
    ongoru_gecerli = 1'b0;
    tick();
    chk("t5_drain_dolu", {31'b0, kuyruk_dolu}, 32'h0);
    tick(); tick();
    chk("t5_drain_dogru", {16'b0, dogru_sayac}, 32'd5);
    resolve(1'b0, 32'h0); tick();
    chk("t5_last_guncelle", {31'b0, guncelle_gecerli}, 32'h1);
    chk("t5_last_yanlis", {31'b0, ongoru_yanlis}, 32'h0);
    chk("t5_last_dogru", {16'b0, dogru_sayac}, 32'd6);
    chk("t5_last_hata", {31'b0, hata}, 32'h0);
    idle_inputs(); tick();

    // 4: predicted not taken, actually taken to 0x400
    push(32'h300, 1'b0); tick();
    idle_inputs();
    resolve(1'b1, 32'h400); tick();
    chk("t4_yanlis", {31'b0, ongoru_yanlis}, 32'h1);
    chk("t4_adres", yonlendir_adres, 32'h400);
    chk("t4_yanlis_sayac", {16'b0, yanlis_sayac}, 32'd2);
    chk("t4_temizle", {31'b0, temizle}, 32'h1);
    idle_inputs();

    // 6b: reset in the middle of the flush drops everything at once
    #1;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_temizle", {31'b0, temizle}, 32'h0);
    chk("t6_rst_yanlis", {31'b0, ongoru_yanlis}, 32'h0);
    chk("t6_rst_yonlendir", {31'b0, yonlendir_gecerli}, 32'h0);
    chk("t6_rst_yanlis_sayac", {16'b0, yanlis_sayac}, 32'd0);
    @(negedge saat);
    reset_n = 1'b1;
    tick();
    chk("t6_post_temizle", {31'b0, temizle}, 32'h0);

    // 6a: resolve on an empty queue (only flagged when back in NORMAL)
    resolve(1'b1, 32'h0); tick();
    chk("t6_empty_hata", {31'b0, hata}, 32'h1);
    chk("t6_empty_guncelle", {31'b0, guncelle_gecerli}, 32'h0);
    idle_inputs(); tick();
    chk("t6_hata_sticky", {31'b0, hata}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
